fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter and fetch controller placed directly upstream of the instruction memory.
- Drives the memory's 8-bit address and its FETCH strobe, and captures the registered instruction byte one cycle later.
- Assembles 1- or 2-byte instructions (opcode plus optional operand) and presents them to the decoder with a valid/ready handshake.
- Handles jumps from the execute stage and halts on the HALT opcode.

Parameters:
- PC_RESET, 8'h00, PC value loaded on reset and on start.
- HALT_OP, 8'hFF, opcode that halts fetching.

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin fetching from PC_RESET; sampled only in IDLE
- iAddr  output  8  instruction address to instruction memory
- FETCH  output  1  read strobe to instruction memory
- instr  input  8  registered instruction byte; valid the cycle after FETCH
- opcode  output  8  captured opcode
- operand  output  8  captured operand byte; 8'h00 for 1-byte instructions
- instr_pc  output  8  address of the opcode byte
- instr_valid  output  1  opcode/operand/instr_pc are valid
- dec_ready  input  1  decoder accepts the instruction this cycle
- jmp_en  input  1  jump request, single-cycle pulse
- jmp_addr  input  8  jump target
- halted  output  1  HALT retired; fetching stopped

Behaviour:
- Reset (rst=1 at a clock edge), from any state including mid-fetch:
  - State goes to IDLE; PC=PC_RESET.
  - All outputs go to 0: iAddr=0, FETCH=0, opcode=0, operand=0, instr_pc=0, instr_valid=0, halted=0.
- Instruction length: opcode[7:6]==2'b11 means a 2-byte instruction; all other opcodes are 1-byte. HALT_OP counts as 1-byte.
- FETCH is asserted only in F_OP and F_ARG. iAddr is registered and equals PC in those states.
- States:
  - IDLE: FETCH=0. If start=1, PC<=PC_RESET and go to F_OP.
  - F_OP: FETCH=1, iAddr=PC, instr_pc<=PC. Go to C_OP.
  - C_OP: opcode<=instr; PC<=PC+1.
    - 2-byte opcode: go to F_ARG.
    - Otherwise: operand<=0 and go to HOLD.
  - F_ARG: FETCH=1, iAddr=PC. Go to C_ARG.
  - C_ARG: operand<=instr; PC<=PC+1. Go to HOLD.
  - HOLD: instr_valid=1; outputs are stable until the handshake (instr_valid & dec_ready).
    - On handshake with opcode==HALT_OP: go to HALTED.
    - On handshake otherwise: go to F_OP. instr_valid drops the next cycle.
  - HALTED: halted=1, FETCH=0, instr_valid=0. Leaves only on rst.
- Latency:
  - 1-byte instruction: instr_valid is 3 cycles after start is sampled.
  - 2-byte instruction: 5 cycles after start is sampled.
  - Throughput with dec_ready tied high: 3 cycles per 1-byte instruction, 5 cycles per 2-byte instruction.
- Jumps:
  - jmp_en is honoured in F_OP, C_OP, F_ARG, C_ARG and HOLD. It is ignored in IDLE and HALTED.
  - Effect: PC<=jmp_addr, any partially fetched instruction is discarded, instr_valid<=0, next state F_OP.
  - jmp_en together with a HOLD handshake: the handshake completes (instruction consumed) and the jump target is used as the next PC.
  - jmp_en in HOLD without dec_ready: the held instruction is dropped.
  - jmp_en overrides a HALT handshake in the same cycle: the next state is F_OP, not HALTED.
- Arithmetic:
  - PC is 8-bit and wraps: 8'hFF+1 = 8'h00.
  - A 2-byte instruction at 8'hFF takes its operand from 8'h00.
- rst has priority over jmp_en and start.

Decomposition:
- Shared package fetch_pkg: FSM state encoding (IDLE, F_OP, C_OP, F_ARG, C_ARG, HOLD, HALTED), HALT_OP, the 2-byte opcode-class constant 2'b11, and the PC width of 8.
- Single module. No sub-module is needed; the PC incrementer stays inline.

Test Plan:
- Memory [0]=8'h12, [1]=8'h05; start pulse, dec_ready=1:
  - instr_valid is high 3 cycles after start with opcode=12, operand=00, instr_pc=00.
  - Next instruction: opcode=05, instr_pc=01.
- Memory [0]=8'hC3, [1]=8'h7A, [2]=8'hFF; dec_ready=1:
  - First instruction: opcode=C3, operand=7A, instr_pc=00, valid 5 cycles after start.
  - Then HALT at instr_pc=02; halted=1 one cycle after its handshake; FETCH stays 0 afterwards.
- dec_ready held 0 for 4 cycles in HOLD:
  - opcode, operand, instr_pc and instr_valid are stable.
  - FETCH=0 throughout.
  - Fetch resumes (FETCH=1, iAddr=next PC) the cycle after dec_ready=1.
- jmp_en=1 with jmp_addr=8'h40 during C_ARG:
  - The partial instruction is dropped; no instr_valid for it.
  - Next cycle FETCH=1, iAddr=40; the next valid instruction has instr_pc=40.
- Jump to 8'hFF where [FF]=8'hC1, [00]=8'h99:
  - Result: opcode=C1, operand=99, instr_pc=FF.
  - The next fetch is at iAddr=01.
- rst=1 asserted in F_ARG:
  - Next cycle all outputs are 0 and the state is IDLE; no FETCH until start.
  - A later start fetches from 8'h00.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// PC width and the opcode class that marks a two-byte instruction.
package fetch_pkg;

  localparam int PC_W = 8;
  localparam logic [7:0] HALT_OP_DEFAULT = 8'hFF;
  localparam logic [1:0] LONG_CLASS = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    F_OP,
    C_OP,
    F_ARG,
    C_ARG,
    HOLD,
    HALTED
  } state_t;

endpackage

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer in front of a registered instruction
// memory; assembles 1/2-byte instructions and hands them to the decoder.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_RESET = 8'h00,
  parameter logic [7:0]      HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] iAddr,
  output logic            FETCH,
  input  logic [7:0]      instr,
  output logic [7:0]      opcode,
  output logic [7:0]      operand,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            dec_ready,
  input  logic            jmp_en,
  input  logic [PC_W-1:0] jmp_addr,
  output logic            halted
);

  state_t          state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic            jump_taken;
  logic            long_instr;

  // The HALT opcode falls in the long class but is treated as a single byte.
  assign long_instr = (instr[7:6] == LONG_CLASS) && (instr != HALT_OP);
  assign jump_taken = jmp_en && (state inside {F_OP, C_OP, F_ARG, C_ARG, HOLD});

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= PC_RESET;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      IDLE: begin
        if (start) begin
          pc_next    = PC_RESET;
          state_next = F_OP;
        end
      end
      F_OP:  state_next = C_OP;
      C_OP: begin
        pc_next    = pc + 1'b1;
        state_next = long_instr ? F_ARG : HOLD;
      end
      F_ARG: state_next = C_ARG;
      C_ARG: begin
        pc_next    = pc + 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (dec_ready)
          state_next = (opcode == HALT_OP) ? HALTED : F_OP;
      end
      HALTED: state_next = HALTED;
      default: state_next = IDLE;
    endcase
    // A jump discards any partial instruction but still lets a HOLD handshake complete.
    if (jump_taken) begin
      pc_next    = jmp_addr;
      state_next = F_OP;
    end
  end

  // Memory-facing strobes are registered from the next state so they line up with F_OP/F_ARG.
  always_ff @(posedge clk) begin
    if (rst) begin
      iAddr       <= '0;
      FETCH       <= 1'b0;
      opcode      <= '0;
      operand     <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      FETCH       <= (state_next == F_OP) || (state_next == F_ARG);
      instr_valid <= (state_next == HOLD);
      halted      <= (state_next == HALTED);
      if ((state_next == F_OP) || (state_next == F_ARG))
        iAddr <= pc_next;
      if (!jump_taken) begin
        case (state)
          F_OP: instr_pc <= pc;
          C_OP: begin
            opcode <= instr;
            if (!long_instr)
              operand <= '0;
          end
          C_ARG: operand <= instr;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered instruction memory model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst, start, dec_ready, jmp_en;
  logic [7:0] jmp_addr;
  logic [7:0] iAddr, opcode, operand, instr_pc;
  logic       FETCH, instr_valid, halted;
  logic [7:0] instr = 8'h00;
  logic [7:0] mem [256];
  int         errors = 0;
  int         checks = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .iAddr(iAddr), .FETCH(FETCH),
    .instr(instr), .opcode(opcode), .operand(operand), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .dec_ready(dec_ready), .jmp_en(jmp_en),
    .jmp_addr(jmp_addr), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (FETCH) instr <= mem[iAddr];

  // Inputs change just after a falling edge; outputs are checked at the next falling edge.
  task automatic applyStimulus(input logic r, input logic s, input logic d,
                               input logic j, input logic [7:0] ja);
    rst = r; start = s; dec_ready = d; jmp_en = j; jmp_addr = ja;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  initial begin
    clearMem();
    mem[0] = 8'h12; mem[1] = 8'h05;
    applyStimulus(1, 0, 0, 0, 8'h00);
    checkOutput("rst_iaddr", iAddr, 8'h00);
    checkOutput("rst_fetch", FETCH, 1'b0);
    checkOutput("rst_opcode", opcode, 8'h00);
    checkOutput("rst_operand", operand, 8'h00);
    checkOutput("rst_instr_pc", instr_pc, 8'h00);
    checkOutput("rst_valid", instr_valid, 1'b0);
    checkOutput("rst_halted", halted, 1'b0);

    // Two single-byte instructions back to back
    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("s1_fetch", FETCH, 1'b1);
    checkOutput("s1_iaddr", iAddr, 8'h00);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("s1_valid_early", instr_valid, 1'b0);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("s1_valid", instr_valid, 1'b1);
    checkOutput("s1_opcode", opcode, 8'h12);
    checkOutput("s1_operand", operand, 8'h00);
    checkOutput("s1_instr_pc", instr_pc, 8'h00);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("s1_refetch", FETCH, 1'b1);
    checkOutput("s1_refetch_addr", iAddr, 8'h01);
    checkOutput("s1_valid_drop", instr_valid, 1'b0);
    applyStimulus(0, 0, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("s1_valid2", instr_valid, 1'b1);
    checkOutput("s1_opcode2", opcode, 8'h05);
    checkOutput("s1_instr_pc2", instr_pc, 8'h01);

    // Two-byte instruction followed by HALT
    clearMem();
    mem[0] = 8'hC3; mem[1] = 8'h7A; mem[2] = 8'hFF;
    applyStimulus(1, 0, 1, 0, 8'h00);
    applyStimulus(0, 1, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("s2_arg_fetch_addr", iAddr, 8'h01);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("s2_valid_early", instr_valid, 1'b0);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("s2_valid", instr_valid, 1'b1);
    checkOutput("s2_opcode", opcode, 8'hC3);
    checkOutput("s2_operand", operand, 8'h7A);
    checkOutput("s2_instr_pc", instr_pc, 8'h00);
    applyStimulus(0, 0, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("s2_halt_valid", instr_valid, 1'b1);
    checkOutput("s2_halt_opcode", opcode, 8'hFF);
    checkOutput("s2_halt_operand", operand, 8'h00);
    checkOutput("s2_halt_pc", instr_pc, 8'h02);
    checkOutput("s2_not_halted_yet", halted, 1'b0);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("s2_halted", halted, 1'b1);
    checkOutput("s2_halted_valid", instr_valid, 1'b0);
    checkOutput("s2_halted_fetch", FETCH, 1'b0);
    applyStimulus(0, 1, 1, 1, 8'h10);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("s2_halted_stays", halted, 1'b1);
    checkOutput("s2_halted_fetch2", FETCH, 1'b0);

    // Decoder stalls for four cycles in HOLD
    clearMem();
    mem[0] = 8'h12; mem[1] = 8'h05;
    applyStimulus(1, 0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      checkOutput("s3_hold_valid", instr_valid, 1'b1);
      checkOutput("s3_hold_opcode", opcode, 8'h12);
      checkOutput("s3_hold_operand", operand, 8'h00);
      checkOutput("s3_hold_pc", instr_pc, 8'h00);
      checkOutput("s3_hold_fetch", FETCH, 1'b0);
      applyStimulus(0, 0, (k == 3), 0, 8'h00);
    end
    checkOutput("s3_resume_fetch", FETCH, 1'b1);
    checkOutput("s3_resume_addr", iAddr, 8'h01);
    checkOutput("s3_resume_valid", instr_valid, 1'b0);

    // Jump while the operand is being captured
    clearMem();
    mem[0] = 8'hC3; mem[1] = 8'h7A; mem[8'h40] = 8'h12;
    applyStimulus(1, 0, 1, 0, 8'h00);
    applyStimulus(0, 1, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 1, 8'h40);
    checkOutput("s4_jmp_fetch", FETCH, 1'b1);
    checkOutput("s4_jmp_addr", iAddr, 8'h40);
    checkOutput("s4_jmp_valid", instr_valid, 1'b0);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("s4_no_partial", instr_valid, 1'b0);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("s4_valid", instr_valid, 1'b1);
    checkOutput("s4_opcode", opcode, 8'h12);
    checkOutput("s4_instr_pc", instr_pc, 8'h40);

    // Two-byte instruction straddling the PC wrap
    clearMem();
    mem[8'hFF] = 8'hC1; mem[0] = 8'h99;
    applyStimulus(1, 0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 1, 8'hFF);
    checkOutput("s5_jmp_addr", iAddr, 8'hFF);
    applyStimulus(0, 0, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 0, 8'h00);
    checkOutput("s5_wrap_arg_addr", iAddr, 8'h00);
    applyStimulus(0, 0, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 0, 8'h00);
    checkOutput("s5_valid", instr_valid, 1'b1);
    checkOutput("s5_opcode", opcode, 8'hC1);
    checkOutput("s5_operand", operand, 8'h99);
    checkOutput("s5_instr_pc", instr_pc, 8'hFF);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("s5_next_fetch", FETCH, 1'b1);
    checkOutput("s5_next_addr", iAddr, 8'h01);

    // Reset in the middle of an operand fetch
    clearMem();
    mem[0] = 8'hC3; mem[1] = 8'h7A;
    applyStimulus(1, 0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 0, 8'h00);
    checkOutput("s6_in_farg", FETCH, 1'b1);
    applyStimulus(1, 0, 0, 0, 8'h00);
    checkOutput("s6_rst_fetch", FETCH, 1'b0);
    checkOutput("s6_rst_iaddr", iAddr, 8'h00);
    checkOutput("s6_rst_opcode", opcode, 8'h00);
    checkOutput("s6_rst_valid", instr_valid, 1'b0);
    applyStimulus(0, 0, 0, 1, 8'h33);
    checkOutput("s6_idle_jmp_ignored", FETCH, 1'b0);
    applyStimulus(0, 0, 0, 0, 8'h00);
    checkOutput("s6_idle_fetch", FETCH, 1'b0);
    applyStimulus(0, 1, 0, 0, 8'h00);
    checkOutput("s6_restart_fetch", FETCH, 1'b1);
    checkOutput("s6_restart_addr", iAddr, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
